// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: state encoding and default payload geometry shared by the pipeline stage register.
//   Contents: state_t (EMPTY/FULL/SKID), DEF_FIELD_W, DEF_NUM_FIELDS.
package pipe_stage_reg_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;
    localparam int DEF_FIELD_W    = 32;
    localparam int DEF_NUM_FIELDS = 5;
endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// sat_counter: W-bit incrementer that sticks at all-ones instead of wrapping.
//   clk   - clock
//   reset - synchronous active-low clear
//   inc   - add one this cycle
//   count - current value
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
    end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional two-entry skid buffer and stall counter.
//   clk, reset     - clock, synchronous active-low reset
//   flush          - squash all held entries
//   in_valid/ready - upstream handshake, in_data packed payload
//   out_valid/ready- downstream handshake, out_data registered payload
//   stall_cnt      - saturating count of cycles with out_valid & !out_ready
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int NUM_FIELDS = DEF_NUM_FIELDS,
    parameter int FIELD_W    = DEF_FIELD_W,
    parameter int SKID_EN    = 1,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [NUM_FIELDS*FIELD_W-1:0] out_data,
    output logic [CNT_W-1:0]              stall_cnt
);
    localparam int DW = NUM_FIELDS * FIELD_W;

    state_t          state, nxt;
    logic [DW-1:0]   main, main_d, skid, skid_d;
    logic            rdy;
    logic            in_x, out_x;

    assign in_x  = in_valid & in_ready;
    assign out_x = out_valid & out_ready;

    // With a skid entry in_ready is purely registered; without one it may follow
    // out_ready so a full stage can swap payloads with no bubble. rdy doubles as
    // the "out of reset" qualifier in both modes.
    assign in_ready  = (SKID_EN != 0) ? rdy : rdy & ((state == EMPTY) | out_ready);
    assign out_valid = (state != EMPTY);
    assign out_data  = main;

    always_comb begin
        nxt    = state;
        main_d = main;
        skid_d = skid;
        if (flush) begin
            nxt    = EMPTY;
            main_d = '0;
            skid_d = '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_x) begin
                        nxt    = FULL;
                        main_d = in_data;
                    end
                end
                FULL: begin
                    if (in_x && out_x) begin
                        main_d = in_data;
                    end else if (out_x) begin
                        nxt    = EMPTY;
                        main_d = '0;
                    end else if (in_x && SKID_EN != 0) begin
                        nxt    = SKID;
                        skid_d = in_data;
                    end
                end
                SKID: begin
                    if (out_x) begin
                        nxt    = FULL;
                        main_d = skid;
                        skid_d = '0;
                    end
                end
                default: begin
                    nxt    = EMPTY;
                    main_d = '0;
                    skid_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= EMPTY;
            main  <= '0;
            skid  <= '0;
            rdy   <= 1'b0;
        end else begin
            state <= nxt;
            main  <= main_d;
            skid  <= skid_d;
            rdy   <= (nxt != SKID);
        end
    end

    // A squashed entry is not a stall: the flush cycle leaves the count alone.
    sat_counter #(.W(CNT_W)) u_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (out_valid & ~out_ready & ~flush),
        .count (stall_cnt)
    );
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of the default skid stage and a SKID_EN=0, CNT_W=4 stage.
module tb_pipe_stage_reg;
    localparam int DW = 160;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [DW-1:0] a_out_data, b_out_data;
    logic [15:0]   a_stall;
    logic [3:0]    b_stall;
    int            checks = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .stall_cnt(a_stall)
    );

    pipe_stage_reg #(.SKID_EN(0), .CNT_W(4)) dut_n (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .stall_cnt(b_stall)
    );

    function automatic logic [DW-1:0] mk(input logic [31:0] v);
        logic [DW-1:0] r;
        for (int k = 0; k < 5; k++) r[k*32 +: 32] = v ^ (32'(k) << 20);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic chk_a(input string name, input logic v, input logic [DW-1:0] d,
                         input logic r, input logic [15:0] s);
        checks++;
        if (a_out_valid !== v || a_out_data !== d || a_in_ready !== r || a_stall !== s) begin
            failures++;
            $display("FAIL %s: got valid=%b ready=%b stall=%0d data=%h, want valid=%b ready=%b stall=%0d data=%h",
                     name, a_out_valid, a_in_ready, a_stall, a_out_data, v, r, s, d);
        end
    endtask

    task automatic chk_b(input string name, input logic v, input logic [DW-1:0] d,
                         input logic r, input logic [3:0] s);
        checks++;
        if (b_out_valid !== v || b_out_data !== d || b_in_ready !== r || b_stall !== s) begin
            failures++;
            $display("FAIL %s: got valid=%b ready=%b stall=%0d data=%h, want valid=%b ready=%b stall=%0d data=%h",
                     name, b_out_valid, b_in_ready, b_stall, b_out_data, v, r, s, d);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; flush = 1'b1; in_valid = 1'b1; out_ready = 1'b0; in_data = mk(32'h1);
        step();
        step();
        chk_a("reset_held", 1'b0, '0, 1'b0, 16'd0);
        chk_b("reset_held_n", 1'b0, '0, 1'b0, 4'd0);
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        step();
        chk_a("reset_release", 1'b0, '0, 1'b1, 16'd0);
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = mk(32'h100); step();
        chk_a("stream_100", 1'b1, mk(32'h100), 1'b1, 16'd0);
        in_data = mk(32'h104); step();
        chk_a("stream_104", 1'b1, mk(32'h104), 1'b1, 16'd0);
        in_data = mk(32'h108); step();
        chk_a("stream_108", 1'b1, mk(32'h108), 1'b1, 16'd0);
        in_valid = 1'b0; step();
        chk_a("stream_drain", 1'b0, '0, 1'b1, 16'd0);
    endtask

    task automatic test_skid();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = mk(32'hA); step();
        chk_a("skid_full", 1'b1, mk(32'hA), 1'b1, 16'd0);
        in_data = mk(32'hB); step();
        chk_a("skid_enter", 1'b1, mk(32'hA), 1'b0, 16'd1);
        in_valid = 1'b0; in_data = mk(32'hF); step(); step();
        chk_a("skid_hold", 1'b1, mk(32'hA), 1'b0, 16'd3);
        out_ready = 1'b1; step();
        chk_a("skid_pop_b", 1'b1, mk(32'hB), 1'b1, 16'd3);
        step();
        chk_a("skid_empty", 1'b0, '0, 1'b1, 16'd3);
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = mk(32'hC); step();
        in_data = mk(32'hD); step();
        chk_a("flush_pre", 1'b1, mk(32'hC), 1'b0, 16'd4);
        flush = 1'b1; in_data = mk(32'hE); step();
        chk_a("flush_kill", 1'b0, '0, 1'b1, 16'd4);
        flush = 1'b0; in_valid = 1'b0; step();
        chk_a("flush_after", 1'b0, '0, 1'b1, 16'd4);
    endtask

    task automatic test_saturate();
        do_reset();
        out_ready = 1'b0; in_valid = 1'b1; in_data = mk(32'h55);
        step();
        chk_b("sat_load", 1'b1, mk(32'h55), 1'b0, 4'd0);
        in_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) chk_b("sat_14", 1'b1, mk(32'h55), 1'b0, 4'd14);
            if (i == 15) chk_b("sat_15", 1'b1, mk(32'h55), 1'b0, 4'd15);
        end
        chk_b("sat_20", 1'b1, mk(32'h55), 1'b0, 4'd15);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; in_valid = 1'b1; in_data = mk(32'h66);
        #1;
        chk_b("b2b_ready", 1'b1, mk(32'h55), 1'b1, 4'd15);
        step();
        chk_b("b2b_66", 1'b1, mk(32'h66), 1'b1, 4'd15);
        in_data = mk(32'h77); step();
        chk_b("b2b_77", 1'b1, mk(32'h77), 1'b1, 4'd15);
        in_valid = 1'b0; step();
        chk_b("b2b_drain", 1'b0, '0, 1'b1, 4'd15);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_skid();
        test_flush();
        test_saturate();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
